// File: rtl/mrr_log2_pkg.sv
// mrr_log2_pkg: shared mode encoding and bus-width helper for the log2 codec
// Contents: mode_e (EXPAND/FLOOR/CEIL/RSVD), num_w() = 2**log2_width + 1
package mrr_log2_pkg;
    typedef enum logic [1:0] {
        MODE_EXPAND = 2'd0,
        MODE_FLOOR  = 2'd1,
        MODE_CEIL   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    function automatic int num_w(input int l2w);
        return (1 << l2w) + 1;
    endfunction
endpackage

// File: rtl/mrr_log2_prienc.sv
// mrr_log2_prienc: combinational highest-set-bit encoder with power-of-two detect
// Ports: i_num operand; o_idx index of highest set bit (0 when none);
//        o_any operand nonzero; o_pow2 exactly one bit set
module mrr_log2_prienc #(
    parameter int W  = 17,
    parameter int IW = 5
)(
    input  logic [W-1:0]  i_num,
    output logic [IW-1:0] o_idx,
    output logic          o_any,
    output logic          o_pow2
);
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++)
            if (i_num[i]) o_idx = IW'(i);
    end

    assign o_any  = |i_num;
    assign o_pow2 = o_any && ((i_num & (i_num - W'(1))) == '0);
endmodule

// File: rtl/mrr_log2_codec.sv
// mrr_log2_codec: two-stage valid/ready power-of-two codec (expand, floor-log2, ceil-log2)
// Ports: clk, rst_n (async low), clr (sync flush);
//        in_valid/in_ready/in_mode/in_log2/in_num input beat;
//        out_valid/out_ready/out_log2/out_num/out_mask/out_exact/out_err result beat
module mrr_log2_codec
    import mrr_log2_pkg::*;
#(
    parameter  int LOG2_WIDTH = 4,
    localparam int NUM_W      = num_w(LOG2_WIDTH),
    localparam int KW         = LOG2_WIDTH + 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [LOG2_WIDTH-1:0] in_log2,
    input  logic [NUM_W-1:0]      in_num,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KW-1:0]         out_log2,
    output logic [NUM_W-1:0]      out_num,
    output logic [NUM_W-1:0]      out_mask,
    output logic                  out_exact,
    output logic                  out_err
);
    localparam int N = 1 << LOG2_WIDTH;

    logic             r_s1_valid, r_s1_pow2, r_s1_zero, r_s2_valid;
    mode_e            r_s1_mode;
    logic [KW-1:0]    r_s1_idx, r_log2;
    logic [NUM_W-1:0] r_num, r_mask;
    logic             r_exact, r_err;

    logic             w_s1_ld, w_s2_ld, w_any, w_pow2, w_err, w_exact;
    logic [KW-1:0]    w_idx, w_k;
    logic [NUM_W-1:0] w_num;
    mode_e            w_mode;

    mrr_log2_prienc #(.W(NUM_W), .IW(KW)) u_prienc (
        .i_num  (in_num),
        .o_idx  (w_idx),
        .o_any  (w_any),
        .o_pow2 (w_pow2)
    );

    assign w_mode   = mode_e'(in_mode);
    assign w_s2_ld  = !r_s2_valid || out_ready;
    assign w_s1_ld  = !r_s1_valid || w_s2_ld;
    assign in_ready = w_s1_ld && !clr && rst_n;

    // CEIL rounds up unless the operand is already a power of two; the
    // widened k lets an overflow past N be detected instead of wrapping.
    always_comb begin
        w_k     = r_s1_idx + KW'(r_s1_mode == MODE_CEIL && !r_s1_pow2);
        w_err   = r_s1_mode == MODE_RSVD || (r_s1_mode != MODE_EXPAND && r_s1_zero) || w_k > KW'(N);
        w_exact = !w_err && (r_s1_mode == MODE_EXPAND || r_s1_pow2);
        w_num   = w_err ? '0 : NUM_W'(1) << w_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_EXPAND;
            r_s1_idx   <= '0;
            r_s1_pow2  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_log2     <= '0;
            r_num      <= '0;
            r_mask     <= '0;
            r_exact    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= clr ? 1'b0 : (w_s1_ld ? in_valid && in_ready : r_s1_valid);
            r_s2_valid <= clr ? 1'b0 : (w_s2_ld ? r_s1_valid : r_s2_valid);
            if (in_valid && in_ready) begin
                r_s1_mode <= w_mode;
                r_s1_idx  <= w_mode == MODE_EXPAND ? KW'(in_log2) : w_idx;
                r_s1_pow2 <= w_pow2;
                r_s1_zero <= !w_any;
            end
            if (w_s2_ld && r_s1_valid) begin
                r_log2  <= w_err ? '0 : w_k;
                r_num   <= w_num;
                r_mask  <= w_err ? '0 : w_num - NUM_W'(1);
                r_exact <= w_exact;
                r_err   <= w_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_log2  = r_log2;
    assign out_num   = r_num;
    assign out_mask  = r_mask;
    assign out_exact = r_exact;
    assign out_err   = r_err;
endmodule

// File: tb/tb_mrr_log2_codec.sv
// tb_mrr_log2_codec: table-driven check of mrr_log2_codec plus backpressure, clr and reset sequences
module tb_mrr_log2_codec;
    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0]  in_mode = 2'd0;
    logic [3:0]  in_log2 = 4'd0;
    logic [16:0] in_num = 17'd0;
    logic        in_ready, out_valid, out_exact, out_err;
    logic [4:0]  out_log2;
    logic [16:0] out_num, out_mask;

    mrr_log2_codec #(.LOG2_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_log2   (in_log2),
        .in_num    (in_num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_log2  (out_log2),
        .out_num   (out_num),
        .out_mask  (out_mask),
        .out_exact (out_exact),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  l2;
        logic [16:0] num;
        logic [4:0]  e_l2;
        logic [16:0] e_num;
        logic [16:0] e_mask;
        logic        e_exact;
        logic        e_err;
    } vec_t;

    vec_t tv[16];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [40:0] res();
        return {out_log2, out_num, out_mask, out_exact, out_err};
    endfunction

    function automatic logic [40:0] exp_of(input vec_t v);
        return {v.e_l2, v.e_num, v.e_mask, v.e_exact, v.e_err};
    endfunction

    task automatic drive(input int i);
        in_mode = tv[i].mode;
        in_log2 = tv[i].l2;
        in_num  = tv[i].num;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         bp_ix[6] = '{0, 1, 2, 3, 7, 10};
    int         sent, rcv, stall, nv;
    bit         hs_in, hs_out, hold, saw_block;
    logic [40:0] snap;

    initial begin
        tv[0]  = '{2'd0, 4'd5,  17'h01234, 5'd5,  17'h00020, 17'h0001F, 1'b1, 1'b0};
        tv[1]  = '{2'd1, 4'd0,  17'd100,   5'd6,  17'd64,    17'h0003F, 1'b0, 1'b0};
        tv[2]  = '{2'd2, 4'd0,  17'd100,   5'd7,  17'd128,   17'h0007F, 1'b0, 1'b0};
        tv[3]  = '{2'd2, 4'd0,  17'd64,    5'd6,  17'd64,    17'h0003F, 1'b1, 1'b0};
        tv[4]  = '{2'd1, 4'd3,  17'd0,     5'd0,  17'd0,     17'd0,     1'b0, 1'b1};
        tv[5]  = '{2'd2, 4'd0,  17'h10001, 5'd0,  17'd0,     17'd0,     1'b0, 1'b1};
        tv[6]  = '{2'd3, 4'd4,  17'd8,     5'd0,  17'd0,     17'd0,     1'b0, 1'b1};
        tv[7]  = '{2'd1, 4'd0,  17'h10000, 5'd16, 17'h10000, 17'h0FFFF, 1'b1, 1'b0};
        tv[8]  = '{2'd0, 4'd0,  17'h1FFFF, 5'd0,  17'd1,     17'd0,     1'b1, 1'b0};
        tv[9]  = '{2'd2, 4'd0,  17'h10000, 5'd16, 17'h10000, 17'h0FFFF, 1'b1, 1'b0};
        tv[10] = '{2'd2, 4'd0,  17'h0FFFF, 5'd16, 17'h10000, 17'h0FFFF, 1'b0, 1'b0};
        tv[11] = '{2'd1, 4'd0,  17'd1,     5'd0,  17'd1,     17'd0,     1'b1, 1'b0};
        tv[12] = '{2'd0, 4'd15, 17'd0,     5'd15, 17'h08000, 17'h07FFF, 1'b1, 1'b0};
        tv[13] = '{2'd2, 4'd0,  17'h08001, 5'd16, 17'h10000, 17'h0FFFF, 1'b0, 1'b0};
        tv[14] = '{2'd2, 4'd0,  17'h10002, 5'd0,  17'd0,     17'd0,     1'b0, 1'b1};
        tv[15] = '{2'd1, 4'd0,  17'h0FFFF, 5'd15, 17'h08000, 17'h07FFF, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {out_valid, res()}, 42'd0);
        chk("reset_in_ready", in_ready, 0);
        #2 rst_n = 1'b1;
        #1 chk("post_reset_in_ready", in_ready, 1);
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(i);
            in_valid = 1'b1;
            #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), out_valid, 0);
            tick();
            chk($sformatf("vec%0d_lat2", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), res(), exp_of(tv[i]));
        end
        tick();

        sent = 0; rcv = 0; stall = 0; saw_block = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (stall == 0);
            in_valid  = sent < 6;
            if (sent < 6) drive(bp_ix[sent]);
            #1;
            if (in_valid && !in_ready) saw_block = 1;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (rcv < 6) chk($sformatf("bp_beat%0d", rcv), res(), exp_of(tv[bp_ix[rcv]]));
                else chk("bp_extra_beat", 1, 0);
                rcv++;
            end
            if (stall > 0) stall--;
            if (hs_out && rcv == 1) stall = 4;
            hold = out_valid && !out_ready;
            snap = res();
            tick();
            if (hold) chk("bp_hold", {out_valid, res()}, {1'b1, snap});
            if (hs_in) sent++;
        end
        chk("bp_sent", sent, 6);
        chk("bp_received", rcv, 6);
        chk("bp_in_ready_dropped", saw_block, 1);
        chk("bp_drained", out_valid, 0);

        out_ready = 1'b1;
        drive(1); in_valid = 1'b1; tick();
        drive(2); tick();
        out_ready = 1'b0;
        clr = 1'b1;
        drive(3);
        #1 chk("clr_in_ready", in_ready, 0);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        out_ready = 1'b1;
        #1 chk("clr_after_in_ready", in_ready, 1);
        nv = 0;
        repeat (5) begin
            tick();
            if (out_valid) nv++;
        end
        chk("clr_no_stale", nv, 0);

        drive(0); in_valid = 1'b1; tick();
        drive(1); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_out", {out_valid, res()}, 42'd0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        chk("rst_hold_in_ready", in_ready, 0);
        chk("rst_hold_out", {out_valid, res()}, 42'd0);
        #2 rst_n = 1'b1;
        #1 chk("rst_rel_in_ready", in_ready, 1);
        chk("rst_rel_out_valid", out_valid, 0);
        drive(12); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rst_first_lat1", out_valid, 0);
        tick();
        chk("rst_first_lat2", out_valid, 1);
        chk("rst_first_result", res(), exp_of(tv[12]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
